tmds_clk_rst_seq: RTL and testbench

TMDS_CLK_RST_SEQ -- requirements
Module: tmds_clk_rst_seq

---
 rtl/tmds_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/tmds_clk_rst_seq.sv | 112 +++++++++++
 tb/tb_tmds_clk_rst_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared state encodings, default timings and helpers for TMDS clock/reset sequencing
package tmds_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_SER   = 3'd3,
        ST_RUN       = 3'd4
    } tmds_state_e;

    localparam int unsigned DEF_PLL_RST_CYC      = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_SER_TO_PIX_CYC   = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 1048576;
    localparam int          CNT_W                = 20;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tmds_clk_rst_seq.sv
// rtl/tmds_clk_rst_seq.sv - PLL reset / lock qualification and serdes/pixel reset release sequencer
module tmds_clk_rst_seq
    import tmds_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned SER_TO_PIX_CYC   = DEF_SER_TO_PIX_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       serdes_rst_n,
    output logic       pix_rst_n,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [7:0] timeout_cnt,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] SER_LAST     = CNT_W'(SER_TO_PIX_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = 1;

    tmds_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             relock_hit;
    logic             timeout_hit;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Counter restarts on every state change, including the glitch return to WAIT_LOCK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_PLL_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_ONE;
        end
    end

    // Lock loss is tested before any counter expiry so it always wins.
    always_comb begin
        state_nxt   = state;
        relock_hit  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = ST_PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                 state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = ST_REL_SER;
            end
            ST_REL_SER: begin
                if (!lock_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_hit = 1'b1;
                end else if (cnt == SER_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_hit = 1'b1;
                end
            end
            default: state_nxt = ST_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_reset    <= 1'b1;
            serdes_rst_n <= 1'b0;
            pix_rst_n    <= 1'b0;
            ready        <= 1'b0;
            relock_cnt   <= 8'd0;
            timeout_cnt  <= 8'd0;
        end else begin
            pll_reset    <= (state_nxt == ST_PLL_RST);
            serdes_rst_n <= (state_nxt == ST_REL_SER) || (state_nxt == ST_RUN);
            pix_rst_n    <= (state_nxt == ST_RUN);
            ready        <= (state_nxt == ST_RUN);
            if (relock_hit)  relock_cnt  <= sat_inc(relock_cnt);
            if (timeout_hit) timeout_cnt <= sat_inc(timeout_cnt);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_tmds_clk_rst_seq.sv
// tb/tb_tmds_clk_rst_seq.sv - self-checking bench for tmds_clk_rst_seq
module tb_tmds_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, serdes_rst_n, pix_rst_n, ready;
    logic [7:0] relock_cnt, timeout_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    tmds_clk_rst_seq #(
        .PLL_RST_CYC      (16),
        .LOCK_STABLE_CYC  (1024),
        .SER_TO_PIX_CYC   (8),
        .LOCK_TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .serdes_rst_n (serdes_rst_n),
        .pix_rst_n    (pix_rst_n),
        .ready        (ready),
        .relock_cnt   (relock_cnt),
        .timeout_cnt  (timeout_cnt),
        .state_o      (state_o)
    );

    typedef struct {
        int         ncyc;
        logic       r;
        logic       l;
        logic [2:0] st;
        logic       pr, ser, pix, rdy;
        logic [7:0] rl, to;
    } vec_t;

    vec_t        tbl[$];
    logic [22:0] sb_q[$];

    function automatic vec_t mk(int n, logic r, logic l, logic [2:0] st, logic pr, logic ser,
                                logic pix, logic rdy, logic [7:0] rl, logic [7:0] to);
        vec_t v;
        v.ncyc = n; v.r = r; v.l = l; v.st = st; v.pr = pr; v.ser = ser;
        v.pix = pix; v.rdy = rdy; v.rl = rl; v.to = to;
        return v;
    endfunction

    function automatic logic [22:0] observed();
        return {state_o, pll_reset, serdes_rst_n, pix_rst_n, ready, relock_cnt, timeout_cnt};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ready !== (state_o == 3'd4) || pix_rst_n !== (state_o == 3'd4) ||
                serdes_rst_n !== (state_o == 3'd3 || state_o == 3'd4) ||
                pll_reset !== (state_o == 3'd0)) begin
                failures++;
                $display("FAIL out_decode t=%0t state=%0d pll_reset=%b serdes=%b pix=%b ready=%b",
                         $time, state_o, pll_reset, serdes_rst_n, pix_rst_n, ready);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] exp_v, act_v;
        int hi, lo;

        // Edge numbers in comments count clock edges after the first edge with rst_n=1.
        tbl.push_back(mk(4,     0, 0, 0, 1, 0, 0, 0, 0, 0));   // reset values
        tbl.push_back(mk(15,    1, 0, 0, 1, 0, 0, 0, 0, 0));   // 15: pulse still high
        tbl.push_back(mk(1,     1, 0, 1, 0, 0, 0, 0, 0, 0));   // 16: pll_reset falls
        tbl.push_back(mk(24,    1, 0, 1, 0, 0, 0, 0, 0, 0));   // 40
        tbl.push_back(mk(2,     1, 1, 1, 0, 0, 0, 0, 0, 0));   // 42: lock_s just high
        tbl.push_back(mk(1,     1, 1, 2, 0, 0, 0, 0, 0, 0));   // 43: STABLE
        tbl.push_back(mk(1023,  1, 1, 2, 0, 0, 0, 0, 0, 0));   // 1066
        tbl.push_back(mk(1,     1, 1, 3, 0, 1, 0, 0, 0, 0));   // 1067: lock edge 41 + 2 + 1024
        tbl.push_back(mk(7,     1, 1, 3, 0, 1, 0, 0, 0, 0));   // 1074
        tbl.push_back(mk(1,     1, 1, 4, 0, 1, 1, 1, 0, 0));   // 1075: RUN
        tbl.push_back(mk(10,    1, 1, 4, 0, 1, 1, 1, 0, 0));   // 1085
        tbl.push_back(mk(1,     1, 0, 4, 0, 1, 1, 1, 0, 0));   // 1086: one-cycle drop
        tbl.push_back(mk(1,     1, 1, 4, 0, 1, 1, 1, 0, 0));   // 1087
        tbl.push_back(mk(1,     1, 1, 0, 1, 0, 0, 0, 1, 0));   // 1088: loss in RUN
        tbl.push_back(mk(15,    1, 1, 0, 1, 0, 0, 0, 1, 0));   // 1103
        tbl.push_back(mk(1,     1, 1, 1, 0, 0, 0, 0, 1, 0));   // 1104
        tbl.push_back(mk(1,     1, 1, 2, 0, 0, 0, 0, 1, 0));   // 1105
        tbl.push_back(mk(498,   1, 1, 2, 0, 0, 0, 0, 1, 0));   // 1603
        tbl.push_back(mk(3,     1, 0, 1, 0, 0, 0, 0, 1, 0));   // 1606: glitch at count 500
        tbl.push_back(mk(2,     1, 1, 1, 0, 0, 0, 0, 1, 0));   // 1608
        tbl.push_back(mk(1,     1, 1, 2, 0, 0, 0, 0, 1, 0));   // 1609
        tbl.push_back(mk(1023,  1, 1, 2, 0, 0, 0, 0, 1, 0));   // 2632: full recount
        tbl.push_back(mk(1,     1, 1, 3, 0, 1, 0, 0, 1, 0));   // 2633
        tbl.push_back(mk(5,     1, 1, 3, 0, 1, 0, 0, 1, 0));   // 2638
        tbl.push_back(mk(2,     1, 0, 3, 0, 1, 0, 0, 1, 0));   // 2640: last REL_SER cycle
        tbl.push_back(mk(1,     1, 0, 0, 1, 0, 0, 0, 2, 0));   // 2641: PLL_RST, not RUN
        tbl.push_back(mk(16,    1, 1, 1, 0, 0, 0, 0, 2, 0));   // 2657
        tbl.push_back(mk(1,     1, 1, 2, 0, 0, 0, 0, 2, 0));   // 2658
        tbl.push_back(mk(1024,  1, 1, 3, 0, 1, 0, 0, 2, 0));   // 3682
        tbl.push_back(mk(3,     1, 1, 3, 0, 1, 0, 0, 2, 0));   // 3685
        tbl.push_back(mk(1,     0, 1, 0, 1, 0, 0, 0, 0, 0));   // 3686: mid-sequence reset
        tbl.push_back(mk(15,    1, 1, 0, 1, 0, 0, 0, 0, 0));   // 3701
        tbl.push_back(mk(1,     1, 1, 1, 0, 0, 0, 0, 0, 0));   // 3702: full 16-cycle pulse
        tbl.push_back(mk(1,     1, 1, 2, 0, 0, 0, 0, 0, 0));   // 3703
        tbl.push_back(mk(3,     1, 0, 1, 0, 0, 0, 0, 0, 0));   // 3706
        tbl.push_back(mk(63,    1, 0, 1, 0, 0, 0, 0, 0, 0));   // 3769
        tbl.push_back(mk(1,     1, 0, 0, 1, 0, 0, 0, 0, 1));   // 3770: first timeout
        tbl.push_back(mk(15,    1, 0, 0, 1, 0, 0, 0, 0, 1));   // 3785
        tbl.push_back(mk(1,     1, 0, 1, 0, 0, 0, 0, 0, 1));   // 3786
        tbl.push_back(mk(63,    1, 0, 1, 0, 0, 0, 0, 0, 1));   // 3849
        tbl.push_back(mk(1,     1, 0, 0, 1, 0, 0, 0, 0, 2));   // 3850
        tbl.push_back(mk(20239, 1, 0, 1, 0, 0, 0, 0, 0, 254)); // 24089
        tbl.push_back(mk(1,     1, 0, 0, 1, 0, 0, 0, 0, 255)); // 24090
        tbl.push_back(mk(80,    1, 0, 0, 1, 0, 0, 0, 0, 255)); // 24170: saturated
        tbl.push_back(mk(800,   1, 0, 0, 1, 0, 0, 0, 0, 255)); // 24970

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                rst_n    = tbl[i].r;
                pll_lock = tbl[i].l;
                if (c == tbl[i].ncyc - 1)
                    sb_q.push_back({tbl[i].st, tbl[i].pr, tbl[i].ser, tbl[i].pix, tbl[i].rdy,
                                    tbl[i].rl, tbl[i].to});
                @(posedge clk);
                #1;
                mon_en = 1'b1;
                if (c == tbl[i].ncyc - 1) begin
                    exp_v = sb_q.pop_front();
                    act_v = observed();
                    checks++;
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL vec%0d state/pr/ser/pix/rdy/relock/timeout actual=%0d/%b/%b/%b/%b/%0d/%0d required=%0d/%b/%b/%b/%b/%0d/%0d",
                                 i, act_v[22:20], act_v[19], act_v[18], act_v[17], act_v[16],
                                 act_v[15:8], act_v[7:0], exp_v[22:20], exp_v[19], exp_v[18],
                                 exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
                    end
                end
            end
        end

        // No-lock re-pulse: measure the pll_reset high and low widths directly.
        hi = 0;
        while (pll_reset === 1'b1 && hi < 200) begin
            hi++;
            @(posedge clk);
            #1;
        end
        lo = 0;
        while (pll_reset === 1'b0 && lo < 200) begin
            lo++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (hi != 16) begin
            failures++;
            $display("FAIL pulse_high actual=%0d required=16", hi);
        end
        checks++;
        if (lo != 64) begin
            failures++;
            $display("FAIL pulse_low actual=%0d required=64", lo);
        end
        checks++;
        if (timeout_cnt !== 8'd255) begin
            failures++;
            $display("FAIL timeout_hold actual=%0d required=255", timeout_cnt);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
